alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-004 SHALL have ports reqN_ready  output  1  scheduler accepts requester N this cycle.
REQ-005 SHALL have ports reqN_a, reqN_b  input  5  operands of requester N.
REQ-006 SHALL have ports reqN_op  input  2  opcode of requester N (00 add, 01 sub, 10 mul, 11 passed through unchanged).
REQ-007 SHALL have ports alu_num1, alu_num2  output  5  operands driven to the shared 5-bit ALU.
REQ-008 SHALL have port alu_operation  output  2  opcode driven to the shared ALU.
REQ-009 SHALL have port alu_out  input  5  combinational ALU result.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-012 SHALL have port rsp_data  output  5  captured ALU result.
REQ-013 SHALL have port rsp_id  output  1  index of the requester that owns rsp_data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM with states IDLE, EXEC and RESP.
REQ-016 In IDLE, SHALL assert reqN_ready combinationally only for the granted requester, and only when its reqN_valid is high; at most one reqN_ready high per cycle.
REQ-017 Handshake (reqN_valid && reqN_ready) at edge T SHALL latch reqN_a/b/op into operand registers and the grant index, then IDLE->EXEC.
REQ-018 alu_num1/alu_num2/alu_operation SHALL be driven from the operand registers only, stable from EXEC through RESP.
REQ-019 In EXEC (one cycle), SHALL capture alu_out into rsp_data and the grant index into rsp_id, then EXEC->RESP.
REQ-020 In RESP, SHALL hold rsp_valid=1 with rsp_data/rsp_id stable until rsp_ready=1; on that edge RESP->IDLE.
REQ-021 Latency: accept at edge T, rsp_valid high in cycle after edge T+1; max throughput one operation per 3 cycles with rsp_ready tied high.
REQ-022 SHALL not accept requests in EXEC or RESP (both reqN_ready=0).
REQ-023 Both valid in IDLE: grant follows arbitration policy (REQ-028/029); non-granted requester SHALL wait with its inputs held.
REQ-024 SHALL not modify the ALU result; 5-bit wrap-around and truncation are the ALU's and are reported as-is.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, operand registers=0 (alu_* outputs 0), busy=0, priority pointer to requester 0.
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight operation; no response SHALL be produced for it.
REQ-027 reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-028 With macro ALU_SCHED_RR_EN defined, SHALL arbitrate round-robin: pointer toggles to the other requester after each grant; after reset requester 0 has priority.
REQ-029 Without ALU_SCHED_RR_EN, SHALL use fixed priority: requester 0 always wins when both valid; no pointer register.

Verification
REQ-030 req0: a=2,b=2,op=00, rsp_ready=1 -> req0_ready=1 in IDLE, rsp_valid two edges after accept, rsp_data=4, rsp_id=0.
REQ-031 req1: a=3,b=2,op=10 -> rsp_data=6, rsp_id=1; then a=3,b=1,op=01 -> rsp_data=2.
REQ-032 Both valid continuously, RR_EN defined -> grants 0,1,0,1; RR_EN undefined -> grants 0,0,0 and req1 never ready.
REQ-033 rsp_ready low 3 cycles in RESP -> rsp_valid, rsp_data, rsp_id, busy held; no new accept until release.
REQ-034 req0 a=31,b=1,op=00 -> rsp_data=0 (wrap passed through).
REQ-035 rst_n=0 for one edge during EXEC -> IDLE, rsp_valid never asserted for that operation, next request served normally.

Source files
------------

// File: rtl/alu_sched_if.sv
// Request, ALU and response signals of the alu_sched scheduler.
// The slave modport is the scheduler; master is the requester/ALU/consumer side.
interface alu_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [4:0] req0_a;
    logic [4:0] req0_b;
    logic [1:0] req0_op;
    logic       req1_valid;
    logic       req1_ready;
    logic [4:0] req1_a;
    logic [4:0] req1_b;
    logic [1:0] req1_op;
    logic [4:0] alu_num1;
    logic [4:0] alu_num2;
    logic [1:0] alu_operation;
    logic [4:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic       rsp_id;
    logic       busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_num1, alu_num2, alu_operation,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_num1, alu_num2, alu_operation,
        output rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler for a shared combinational 5-bit ALU (IDLE -> EXEC -> RESP).
// Define ALU_SCHED_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_sched (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [4:0] num1;
    logic [4:0] num2;
    logic [1:0] op;
    logic       gnt_id;
    logic [4:0] data;
    logic       id;
    logic       grant;
    logic       accept;

`ifdef ALU_SCHED_RR_EN
    logic ptr;

    // ptr names the requester that wins a tie; a lone requester always wins
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ptr;
        else                                  grant = bus.req1_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      ptr <= 1'b0;
        else if (accept) ptr <= ~grant;
    end
`else
    always_comb grant = bus.req1_valid && !bus.req0_valid;
`endif

    always_comb begin
        bus.req0_ready = rst_n && (state == IDLE) && bus.req0_valid && !grant;
        bus.req1_ready = rst_n && (state == IDLE) && bus.req1_valid && grant;
    end

    assign accept = bus.req0_ready || bus.req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            num1   <= '0;
            num2   <= '0;
            op     <= '0;
            gnt_id <= 1'b0;
            data   <= '0;
            id     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    num1   <= grant ? bus.req1_a  : bus.req0_a;
                    num2   <= grant ? bus.req1_b  : bus.req0_b;
                    op     <= grant ? bus.req1_op : bus.req0_op;
                    gnt_id <= grant;
                    state  <= EXEC;
                end
                EXEC: begin
                    data  <= bus.alu_out;
                    id    <= gnt_id;
                    state <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alu_num1      = num1;
    assign bus.alu_num2      = num2;
    assign bus.alu_operation = op;
    assign bus.rsp_valid     = (state == RESP);
    assign bus.rsp_data      = data;
    assign bus.rsp_id        = id;
    assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_sched_if bus ();

    alu_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef ALU_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic logic [4:0] alu_f(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
        case (o)
            2'b00:   return 5'(a + b);
            2'b01:   return 5'(a - b);
            2'b10:   return 5'(a * b);
            default: return a;
        endcase
    endfunction

    always_comb bus.alu_out = alu_f(bus.alu_num1, bus.alu_num2, bus.alu_operation);

    int total = 0;
    int bad = 0;

    // requester-side pending operations, held until the model sees them accepted
    bit         p_valid [2];
    logic [4:0] p_a [2];
    logic [4:0] p_b [2];
    logic [1:0] p_op [2];
    bit         rdy = 1'b1;
    bit         rnd_mode = 1'b0;
    bit         cont_mode = 1'b0;

    // model of the in-flight operation
    bit          outstanding = 1'b0;
    int unsigned age = 0;
    logic [4:0]  e_a, e_b, e_res;
    logic [1:0]  e_op;
    bit          e_id;
    bit          last = 1'b1;

    int          obs_grants [$];
    logic [4:0]  obs_data;
    logic        obs_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit pick_grant();
        if (p_valid[0] && p_valid[1]) return RR ? !last : 1'b0;
        return p_valid[1];
    endfunction

    task automatic drive();
        if (rnd_mode) begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (!p_valid[n] && $urandom_range(0, 1) == 1) begin
                    p_valid[n] = 1'b1;
                    p_a[n]     = 5'($urandom);
                    p_b[n]     = 5'($urandom);
                    p_op[n]    = 2'($urandom);
                end
            end
            rdy   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 40) != 0);
        end
        if (cont_mode) begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (!p_valid[n]) begin
                    p_valid[n] = 1'b1;
                    p_a[n]     = 5'(n + 1);
                    p_b[n]     = 5'd3;
                    p_op[n]    = 2'b00;
                end
            end
        end
        bus.req0_valid = p_valid[0];
        bus.req0_a     = p_a[0];
        bus.req0_b     = p_b[0];
        bus.req0_op    = p_op[0];
        bus.req1_valid = p_valid[1];
        bus.req1_a     = p_a[1];
        bus.req1_b     = p_b[1];
        bus.req1_op    = p_op[1];
        bus.rsp_ready  = rdy;
    endtask

    task automatic issue(input int unsigned n, input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
        p_valid[n] = 1'b1;
        p_a[n]     = a;
        p_b[n]     = b;
        p_op[n]    = o;
        drive();
    endtask

    // One clock: check at negedge, advance the model at posedge, drive new inputs just after
    task automatic cycle();
        bit g, e_r0, e_r1;
        @(negedge clk);
        g    = pick_grant();
        e_r0 = rst_n && !outstanding && p_valid[0] && !g;
        e_r1 = rst_n && !outstanding && p_valid[1] && g;
        check("req0_ready", bus.req0_ready, e_r0);
        check("req1_ready", bus.req1_ready, e_r1);
        check("rsp_valid", bus.rsp_valid, outstanding && age >= 1);
        check("busy", bus.busy, outstanding);
        if (outstanding) begin
            check("alu_num1", bus.alu_num1, e_a);
            check("alu_num2", bus.alu_num2, e_b);
            check("alu_operation", bus.alu_operation, e_op);
            if (age >= 1) begin
                check("rsp_data", bus.rsp_data, e_res);
                check("rsp_id", bus.rsp_id, e_id);
            end
        end
        if (bus.req0_ready === 1'b1)      obs_grants.push_back(0);
        else if (bus.req1_ready === 1'b1) obs_grants.push_back(1);
        if (bus.rsp_valid === 1'b1) begin
            obs_data = bus.rsp_data;
            obs_id   = bus.rsp_id;
        end
        @(posedge clk);
        if (!rst_n) begin
            outstanding = 1'b0;
            age         = 0;
            last        = 1'b1;
        end else if (outstanding) begin
            if (age >= 1 && rdy) outstanding = 1'b0;
            else                 age++;
        end else if (e_r0 || e_r1) begin
            outstanding = 1'b1;
            age         = 0;
            e_id        = e_r1;
            e_a         = p_a[e_id];
            e_b         = p_b[e_id];
            e_op        = p_op[e_id];
            e_res       = alu_f(e_a, e_b, e_op);
            last        = e_id;
            p_valid[e_id] = 1'b0;
        end
        #1;
        drive();
    endtask

    task automatic run_idle(input int unsigned max);
        int unsigned k = 0;
        while ((outstanding || p_valid[0] || p_valid[1]) && k < max) begin
            cycle();
            k++;
        end
    endtask

    initial begin
        p_valid = '{1'b0, 1'b0};
        p_a     = '{5'd0, 5'd0};
        p_b     = '{5'd0, 5'd0};
        p_op    = '{2'd0, 2'd0};
        rst_n   = 1'b0;
        drive();

        // request pending during reset must not be accepted
        issue(0, 5'd2, 5'd2, 2'b00);
        cycle();
        cycle();
        check("rst_num1", bus.alu_num1, 0);
        check("rst_num2", bus.alu_num2, 0);
        check("rst_op", bus.alu_operation, 0);
        check("rst_data", bus.rsp_data, 0);
        check("rst_id", bus.rsp_id, 0);
        check("rst_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        drive();
        run_idle(20);
        check("add_2_2", obs_data, 5'd4);
        check("add_2_2_id", obs_id, 1'b0);

        issue(1, 5'd3, 5'd2, 2'b10);
        run_idle(20);
        check("mul_3_2", obs_data, 5'd6);
        check("mul_3_2_id", obs_id, 1'b1);
        issue(1, 5'd3, 5'd1, 2'b01);
        run_idle(20);
        check("sub_3_1", obs_data, 5'd2);

        issue(0, 5'd31, 5'd1, 2'b00);
        run_idle(20);
        check("add_wrap", obs_data, 5'd0);

        // consumer stalls three cycles while the other requester waits
        rdy = 1'b0;
        issue(0, 5'd5, 5'd6, 2'b00);
        cycle();
        cycle();
        issue(1, 5'd1, 5'd1, 2'b00);
        repeat (3) cycle();
        rdy = 1'b1;
        drive();
        run_idle(20);

        // reset while in EXEC drops the operation
        issue(0, 5'd7, 5'd7, 2'b00);
        cycle();
        rst_n = 1'b0;
        drive();
        cycle();
        check("rst_exec_num1", bus.alu_num1, 0);
        check("rst_exec_valid", bus.rsp_valid, 0);
        rst_n = 1'b1;
        drive();
        repeat (3) cycle();
        issue(1, 5'd4, 5'd4, 2'b10);
        run_idle(20);
        check("after_rst_mul", obs_data, 5'd16);
        check("after_rst_id", obs_id, 1'b1);

        // both requesters continuously valid
        obs_grants.delete();
        cont_mode = 1'b1;
        drive();
        repeat (12) cycle();
        cont_mode = 1'b0;
        check("grant_count", obs_grants.size(), 4);
        for (int unsigned i = 0; i < 4 && i < obs_grants.size(); i++)
            check("grant_seq", obs_grants[i], RR ? (i % 2) : 0);
        run_idle(30);

        rnd_mode = 1'b1;
        drive();
        repeat (2000) cycle();
        rnd_mode = 1'b0;
        rst_n    = 1'b1;
        rdy      = 1'b1;
        drive();
        run_idle(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
